// File: rtl/wb_grf.sv
// wb_grf: writeback stage and general register file of the 5-stage MIPS pipeline.
//
// Selects the writeback datum from the MEM/WB outputs and commits it to a 32x32
// register file. The file serves two combinational D-stage read ports with a
// write-through bypass. It also counts committed register writes.
//
// Parameters:
//   PC_RESET : PC assumed for W_PC after reset (must be word aligned)
//   CNT_W    : width of the committed-write counter
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   W_ALU_O .. W_MD_O  : candidate writeback sources from the W stage
//   W_PC               : PC of the W-stage instruction (link value is W_PC+8)
//   W_A3, W_WDSel      : destination register and source select
//   W_RegWrite         : write enable from W-stage decode
//   D_A1/D_A2          : read addresses; D_RD1/D_RD2 : read data (bypassed)
//   W_WD               : selected writeback data, exported for forwarding
//   wr_count           : committed writes since reset (wraps)
//
// Build option: define GRF_TRACE_EN to print one judge-format trace line per
// committed write. Register and port behaviour is the same either way.
module wb_grf #(
  parameter logic [31:0] PC_RESET = 32'h00003000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      W_ALU_O,
  input  logic [31:0]      W_DM_O,
  input  logic [31:0]      W_PC,
  input  logic [31:0]      W_EXT_O,
  input  logic [31:0]      W_CMP_O,
  input  logic [31:0]      W_MD_O,
  input  logic [4:0]       W_A3,
  input  logic [2:0]       W_WDSel,
  input  logic             W_RegWrite,
  input  logic [4:0]       D_A1,
  input  logic [4:0]       D_A2,
  output logic [31:0]      D_RD1,
  output logic [31:0]      D_RD2,
  output logic [31:0]      W_WD,
  output logic [CNT_W-1:0] wr_count
);

  // Trace output formats PCs as instruction addresses; reject misaligned values.
  if (PC_RESET[1:0] != 2'b00) begin : g_pc_reset_check
    $error("wb_grf: PC_RESET must be word aligned");
  end

  logic [31:0] regs [32] = '{default: '0};
  logic [CNT_W-1:0] count_q = '0;
  logic we;

  always_comb begin
    W_WD = '0;
    case (W_WDSel)
      3'd0:    W_WD = W_ALU_O;
      3'd1:    W_WD = W_DM_O;
      3'd2:    W_WD = W_PC + 32'd8;
      3'd3:    W_WD = W_EXT_O;
      3'd4:    W_WD = W_CMP_O;
      3'd5:    W_WD = W_MD_O;
      default: W_WD = '0;
    endcase
  end

  assign we = W_RegWrite && (W_A3 != 5'd0) && !reset;

  // Bypass is qualified by we, so it is off during reset and for $0.
  always_comb begin
    D_RD1 = '0;
    if (D_A1 != 5'd0) begin
      D_RD1 = (we && D_A1 == W_A3) ? W_WD : regs[D_A1];
    end
  end

  always_comb begin
    D_RD2 = '0;
    if (D_A2 != 5'd0) begin
      D_RD2 = (we && D_A2 == W_A3) ? W_WD : regs[D_A2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      count_q <= '0;
    end else if (we) begin
      regs[W_A3] <= W_WD;
      count_q    <= count_q + CNT_W'(1);
    end
  end

  assign wr_count = count_q;

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (we) begin
      $display("%d@%h: $%d <= %h", $time, W_PC, W_A3, W_WD);
    end
  end
`else
`endif

endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Writeback stage plus general register file of the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline-register outputs, selects the writeback datum, and commits it to a 32x32 register file.
- Serves the two D-stage read ports with write-through bypass.
- Exports the selected writeback value for the forwarding network and counts committed register writes.

Parameters:
- PC_RESET, 32'h00003000, PC value assumed for W_PC after reset; used only by the trace output.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- W_ALU_O  input  32  ALU result from W stage
- W_DM_O  input  32  load data from W stage
- W_PC  input  32  PC of instruction in W stage
- W_EXT_O  input  32  immediate/extender result (lui etc.)
- W_CMP_O  input  32  compare result (slt-class)
- W_MD_O  input  32  HI/LO read value (mfhi/mflo)
- W_A3  input  5  destination register number
- W_WDSel  input  3  writeback source select
- W_RegWrite  input  1  write enable from W-stage decode
- D_A1  input  5  read port 1 address
- D_A2  input  5  read port 2 address
- D_RD1  output  32  read port 1 data
- D_RD2  output  32  read port 2 data
- W_WD  output  32  selected writeback data (forwarding source)
- wr_count  output  CNT_W  number of committed register writes since reset

Behaviour:
- Reset: clk and reset are already decided — reset is synchronous, active-high; clock is clk.
  - On a rising edge with reset=1, all 32 registers are cleared to 0 and wr_count is cleared to 0.
  - Reset overrides any write in the same cycle.
  - Power-up (initial) values equal the reset values.
- W_WDSel decode (combinational):
  - 0 -> W_ALU_O; 1 -> W_DM_O; 2 -> W_PC+8 (32-bit wrap); 3 -> W_EXT_O; 4 -> W_CMP_O; 5 -> W_MD_O.
  - Codes 6 and 7 -> 32'h0.
  - W_WD is always the decoded value, independent of W_RegWrite.
- Effective write: we = W_RegWrite && (W_A3 != 0) && !reset.
  - On a rising edge with we=1: reg[W_A3] <= W_WD and wr_count <= wr_count+1.
  - wr_count wraps from all-ones to 0.
- Register 0:
  - Never written.
  - Reads of address 0 always return 0, including when a write to 0 is attempted.
- Read ports (combinational, zero latency):
  - D_RD1 = (D_A1==0) ? 0 : (we && D_A1==W_A3) ? W_WD : reg[D_A1]. D_RD2 is defined the same way.
  - Bypass makes same-cycle write-then-read return the new value, so no 3-cycle hazard gap.
- Simultaneous events:
  - Both read ports hitting the write address both bypass.
  - Identical D_A1/D_A2 return identical data.
- Reset mid-operation:
  - While reset=1, bypass is disabled (we=0) and reads return the array contents.
  - From the edge after reset onward, reads return 0 for every address.
- X-propagation: no X on any output after the first reset edge, provided inputs are known.

Optional Feature:
- Macro GRF_TRACE_EN.
- Defined: on every rising edge with we=1, the block emits one simulation display line in the format "@%h: $%d <= %h" with W_PC, W_A3 and W_WD, using the course judge format and the time stamp prefix. Attempted writes to $0 print nothing.
- Undefined: no display statements are compiled.
- Register and port behaviour is identical in both builds.

Test Plan:
- Reset: write reg 5 = 32'h1234, assert reset one cycle -> D_RD1 with D_A1=5 reads 0; wr_count=0.
- Basic write/read: WDSel=0, ALU_O=32'hDEADBEEF, A3=8, RegWrite=1; next cycle RegWrite=0, D_A1=8 -> D_RD1=32'hDEADBEEF; wr_count=1.
- Bypass: same cycle A3=9, WDSel=3, EXT_O=32'hABCD0000, D_A1=D_A2=9 -> D_RD1=D_RD2=32'hABCD0000 before the edge.
- $0 protection: A3=0, RegWrite=1, ALU_O=32'hFFFFFFFF -> D_RD1(A1=0)=0, wr_count unchanged, no trace line.
- Source select sweep: W_PC=32'h00003010 with WDSel=2 -> W_WD=32'h00003018; WDSel 1/4/5 route DM/CMP/MD; WDSel=7 -> 0.
- Counter wrap with CNT_W=4: 16 writes to reg 1 -> wr_count returns to 0; reset asserted together with a write -> write is dropped, counter=0.
